// File: rtl/adc_sample_averager.sv
// Block averager for the two ADC channels: accumulates 2^LOG2_AVG frames per window
// and presents the averages plus per-window min/max on a valid/ready output register.
module adc_sample_averager #(
  parameter int DW       = 14,
  parameter int LOG2_AVG = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                smp_strobe,
  input  logic [DW-1:0]       smp_ch1,
  input  logic [DW-1:0]       smp_ch2,
  input  logic                out_ready,
  input  logic                clr_ovf,
  output logic                out_valid,
  output logic [DW-1:0]       avg_ch1,
  output logic [DW-1:0]       avg_ch2,
  output logic [DW-1:0]       min_ch1,
  output logic [DW-1:0]       max_ch1,
  output logic [DW-1:0]       min_ch2,
  output logic [DW-1:0]       max_ch2,
  output logic [LOG2_AVG-1:0] win_cnt,
  output logic                overrun
);

  localparam int AW = DW + LOG2_AVG;
  localparam logic [LOG2_AVG-1:0] LAST_FRAME = '1;
  localparam logic [LOG2_AVG-1:0] CNT_ONE    = LOG2_AVG'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_LOAD
  } state_t;

  state_t r_state;

  logic r_sync1, r_sync2, r_sync3;
  logic w_edge;

  logic signed [AW-1:0] r_accCh1, r_accCh2;
  logic signed [AW-1:0] w_extCh1, w_extCh2;
  logic signed [DW-1:0] w_smpCh1, w_smpCh2;
  logic signed [DW-1:0] r_minCh1, r_maxCh1, r_minCh2, r_maxCh2;
  logic [LOG2_AVG-1:0]  r_winCnt;

  logic                 r_outValid;
  logic                 r_overrun;
  logic [DW-1:0]        r_avgCh1, r_avgCh2;
  logic [DW-1:0]        r_outMin1, r_outMax1, r_outMin2, r_outMax2;
  logic                 w_inLoad;
  logic                 w_loadOk;

  // Only the strobe is synchronised; the data words are stable while it is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= smp_strobe;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_edge   = r_sync2 & ~r_sync3;
  assign w_smpCh1 = signed'(smp_ch1);
  assign w_smpCh2 = signed'(smp_ch2);
  assign w_extCh1 = {{LOG2_AVG{smp_ch1[DW-1]}}, smp_ch1};
  assign w_extCh2 = {{LOG2_AVG{smp_ch2[DW-1]}}, smp_ch2};

  // Window state machine and accumulation datapath; run=0 discards any partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_accCh1 <= '0;
      r_accCh2 <= '0;
      r_minCh1 <= '0;
      r_maxCh1 <= '0;
      r_minCh2 <= '0;
      r_maxCh2 <= '0;
      r_winCnt <= '0;
    end else if (!run) begin
      r_state  <= S_IDLE;
      r_accCh1 <= '0;
      r_accCh2 <= '0;
      r_minCh1 <= '0;
      r_maxCh1 <= '0;
      r_minCh2 <= '0;
      r_maxCh2 <= '0;
      r_winCnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_accCh1 <= '0;
          r_accCh2 <= '0;
          r_minCh1 <= '0;
          r_maxCh1 <= '0;
          r_minCh2 <= '0;
          r_maxCh2 <= '0;
          r_winCnt <= '0;
          r_state  <= S_ACCUM;
        end
        S_ACCUM: begin
          if (w_edge) begin
            r_accCh1 <= r_accCh1 + w_extCh1;
            r_accCh2 <= r_accCh2 + w_extCh2;
            if (r_winCnt == '0) begin
              r_minCh1 <= w_smpCh1;
              r_maxCh1 <= w_smpCh1;
              r_minCh2 <= w_smpCh2;
              r_maxCh2 <= w_smpCh2;
            end else begin
              if (w_smpCh1 < r_minCh1) r_minCh1 <= w_smpCh1;
              if (w_smpCh1 > r_maxCh1) r_maxCh1 <= w_smpCh1;
              if (w_smpCh2 < r_minCh2) r_minCh2 <= w_smpCh2;
              if (w_smpCh2 > r_maxCh2) r_maxCh2 <= w_smpCh2;
            end
            r_winCnt <= r_winCnt + CNT_ONE;
            if (r_winCnt == LAST_FRAME) r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_accCh1 <= '0;
          r_accCh2 <= '0;
          r_minCh1 <= '0;
          r_maxCh1 <= '0;
          r_minCh2 <= '0;
          r_maxCh2 <= '0;
          r_winCnt <= '0;
          r_state  <= S_ACCUM;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_inLoad = (r_state == S_LOAD);
  assign w_loadOk = ~r_outValid | out_ready;

  // Result register: the upper accumulator bits are the arithmetic shift by LOG2_AVG,
  // which floors toward negative infinity. A window finishing under backpressure is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_overrun  <= 1'b0;
      r_avgCh1   <= '0;
      r_avgCh2   <= '0;
      r_outMin1  <= '0;
      r_outMax1  <= '0;
      r_outMin2  <= '0;
      r_outMax2  <= '0;
    end else begin
      if (w_inLoad && w_loadOk) begin
        r_outValid <= 1'b1;
        r_avgCh1   <= r_accCh1[AW-1:LOG2_AVG];
        r_avgCh2   <= r_accCh2[AW-1:LOG2_AVG];
        r_outMin1  <= r_minCh1;
        r_outMax1  <= r_maxCh1;
        r_outMin2  <= r_minCh2;
        r_outMax2  <= r_maxCh2;
      end else if (r_outValid && out_ready) begin
        r_outValid <= 1'b0;
      end

      if (w_inLoad && !w_loadOk) begin
        r_overrun <= 1'b1;
      end else if (clr_ovf) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign out_valid = r_outValid;
  assign overrun   = r_overrun;
  assign avg_ch1   = r_avgCh1;
  assign avg_ch2   = r_avgCh2;
  assign min_ch1   = r_outMin1;
  assign max_ch1   = r_outMax1;
  assign min_ch2   = r_outMin2;
  assign max_ch2   = r_outMax2;
  assign win_cnt   = r_winCnt;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Scoreboard bench for adc_sample_averager: stimulus pushes hand-computed window results,
// a negedge monitor pops and compares each result as it is accepted.
module tb_adc_sample_averager;

  localparam int DW       = 14;
  localparam int LOG2_AVG = 4;

  typedef struct packed {
    logic signed [DW-1:0] avg1;
    logic signed [DW-1:0] avg2;
    logic signed [DW-1:0] min1;
    logic signed [DW-1:0] max1;
    logic signed [DW-1:0] min2;
    logic signed [DW-1:0] max2;
  } res_t;

  logic                clk = 1'b0;
  logic                rstN;
  logic                run;
  logic                smpStrobe;
  logic [DW-1:0]       smpCh1, smpCh2;
  logic                outReady;
  logic                clrOvf;
  logic                outValid;
  logic [DW-1:0]       avgCh1, avgCh2, minCh1, maxCh1, minCh2, maxCh2;
  logic [LOG2_AVG-1:0] winCnt;
  logic                overrun;

  res_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  adc_sample_averager #(.DW(DW), .LOG2_AVG(LOG2_AVG)) dut (
    .clk        (clk),
    .rst_n      (rstN),
    .run        (run),
    .smp_strobe (smpStrobe),
    .smp_ch1    (smpCh1),
    .smp_ch2    (smpCh2),
    .out_ready  (outReady),
    .clr_ovf    (clrOvf),
    .out_valid  (outValid),
    .avg_ch1    (avgCh1),
    .avg_ch2    (avgCh2),
    .min_ch1    (minCh1),
    .max_ch1    (maxCh1),
    .min_ch2    (minCh2),
    .max_ch2    (maxCh2),
    .win_cnt    (winCnt),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Shared by the stimulus thread and the monitor, so it must be automatic.
  task automatic checkOutput(input string name, input logic signed [31:0] act,
                             input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One conversion frame; optionally checks the result latency on the last frame of a window.
  task automatic applyStimulus(input logic signed [DW-1:0] ch1, input logic signed [DW-1:0] ch2,
                               input bit chkLatency);
    step();
    smpStrobe = 1'b1;
    smpCh1    = ch1;
    smpCh2    = ch2;
    if (chkLatency) begin
      repeat (3) @(posedge clk);
      #1;
      checkOutput("valid_before_k3", 32'(outValid), 0);
      @(posedge clk);
      #1;
      checkOutput("valid_at_k3", 32'(outValid), 1);
      #1;
    end else begin
      repeat (4) step();
    end
    smpStrobe = 1'b0;
    repeat (6) step();
  endtask

  task automatic pushResult(input int a1, input int a2, input int mn1, input int mx1,
                            input int mn2, input int mx2);
    res_t r;
    r.avg1 = DW'(a1);
    r.avg2 = DW'(a2);
    r.min1 = DW'(mn1);
    r.max1 = DW'(mx1);
    r.min2 = DW'(mn2);
    r.max2 = DW'(mx2);
    sbq.push_back(r);
  endtask

  // Monitor: every accepted result is compared against the head of the scoreboard.
  always @(negedge clk) begin
    res_t e;
    if (rstN === 1'b1 && outValid === 1'b1 && outReady === 1'b1) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_result: got out_valid=1, expected no pending result");
      end else begin
        e = sbq.pop_front();
        checkOutput("avg_ch1", $signed(avgCh1), $signed(e.avg1));
        checkOutput("avg_ch2", $signed(avgCh2), $signed(e.avg2));
        checkOutput("min_ch1", $signed(minCh1), $signed(e.min1));
        checkOutput("max_ch1", $signed(maxCh1), $signed(e.max1));
        checkOutput("min_ch2", $signed(minCh2), $signed(e.min2));
        checkOutput("max_ch2", $signed(maxCh2), $signed(e.max2));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN      = 1'b0;
    run       = 1'b0;
    smpStrobe = 1'b0;
    smpCh1    = '0;
    smpCh2    = '0;
    outReady  = 1'b1;
    clrOvf    = 1'b0;

    // Strobes toggling under reset, then released with run low.
    run = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(14'(i + 1), 14'(-i), 1'b0);
    checkOutput("rst_valid", 32'(outValid), 0);
    checkOutput("rst_wincnt", 32'(winCnt), 0);
    checkOutput("rst_avg1", 32'(avgCh1), 0);
    checkOutput("rst_overrun", 32'(overrun), 0);
    run = 1'b0;
    step();
    rstN = 1'b1;
    for (int i = 0; i < 2; i++) applyStimulus(14'(5), 14'(5), 1'b0);
    checkOutput("idle_wincnt", 32'(winCnt), 0);
    checkOutput("idle_valid", 32'(outValid), 0);
    run = 1'b1;
    repeat (3) step();

    // Constant window: 100 / -200.
    pushResult(100, -200, 100, 100, -200, -200);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(14'(100), 14'(-200), i == 15);
      if (i == 4) checkOutput("wincnt_5", 32'(winCnt), 5);
    end

    // Full-scale alternation floors to -1; ramp 0..15 averages to 7.
    pushResult(-1, 7, -8192, 8191, 0, 15);
    for (int i = 0; i < 16; i++)
      applyStimulus((i % 2 == 0) ? 14'(8191) : 14'(-8192), 14'(i), 1'b0);

    // Backpressure across two windows: first result held, second dropped.
    outReady = 1'b0;
    pushResult(1000, -1, 1000, 1000, -1, -1);
    for (int i = 0; i < 16; i++) applyStimulus(14'(1000), 14'(-1), 1'b0);
    checkOutput("bp_valid", 32'(outValid), 1);
    checkOutput("bp_no_ovf", 32'(overrun), 0);
    for (int i = 0; i < 16; i++) applyStimulus(14'(5), 14'(5), 1'b0);
    checkOutput("bp_overrun", 32'(overrun), 1);
    checkOutput("bp_held_avg1", $signed(avgCh1), 1000);
    checkOutput("bp_held_avg2", $signed(avgCh2), -1);
    checkOutput("bp_held_valid", 32'(outValid), 1);
    clrOvf = 1'b1;
    step();
    clrOvf = 1'b0;
    checkOutput("clr_ovf", 32'(overrun), 0);
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    checkOutput("valid_drop", 32'(outValid), 0);
    step();
    outReady = 1'b1;

    // Abort after 5 frames; only the following full window counts.
    for (int i = 0; i < 5; i++) applyStimulus(14'(3000), 14'(-3000), 1'b0);
    checkOutput("abort_wincnt_pre", 32'(winCnt), 5);
    run = 1'b0;
    step();
    checkOutput("abort_wincnt", 32'(winCnt), 0);
    run = 1'b1;
    step();
    pushResult(50, 50, 50, 50, 50, 50);
    for (int i = 0; i < 16; i++) applyStimulus(14'(50), 14'(50), 1'b0);

    // Asynchronous reset between clock edges after 10 frames.
    for (int i = 0; i < 10; i++) applyStimulus(14'(7), 14'(7), 1'b0);
    checkOutput("pre_rst_wincnt", 32'(winCnt), 10);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("arst_wincnt", 32'(winCnt), 0);
    checkOutput("arst_avg1", 32'(avgCh1), 0);
    checkOutput("arst_avg2", 32'(avgCh2), 0);
    checkOutput("arst_max1", 32'(maxCh1), 0);
    checkOutput("arst_valid", 32'(outValid), 0);
    step();
    rstN = 1'b1;
    repeat (40) step();
    checkOutput("post_rst_valid", 32'(outValid), 0);
    checkOutput("post_rst_wincnt", 32'(winCnt), 0);
    checkOutput("sb_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
